wshb_fb_slave: RTL and testbench
================================

Name: wshb_fb_slave

Overview:
- Wishbone classic-cycle responder on the frame-buffer bus. It accepts single 32-bit write and read transfers from any pattern or video master and stores them in on-chip word memory.
- It raises a one-cycle frame_done pulse when the last word of the buffer is written, so the display side can swap buffers.
- It also serves as the synthesizable bus target in bench and FPGA bring-up when the SDRAM controller is absent.

Parameters:
DEPTH, 1024, number of 32-bit words stored (must be a power of 2, at least 2)
BASE_ADDR, 32'h0, byte address of word 0 (must be 4-byte aligned)
WAIT_STATES, 0, extra cycles inserted between request sampling and ack (0..15)

Ports:
clk  in  1  bus clock
rst_n  in  1  asynchronous active-low reset
cyc  in  1  bus cycle in progress
stb  in  1  transfer strobe
we  in  1  1 = write, 0 = read
adr  in  32  byte address
sel  in  4  byte-lane enables, sel[i] covers dat_ms[8i+7:8i]
dat_ms  in  32  write data, master to slave
cti  in  3  cycle type identifier, ignored (classic only)
bte  in  2  burst type extension, ignored
dat_sm  out  32  read data, slave to master
ack  out  1  normal transfer termination
err  out  1  error termination
frame_done  out  1  one-cycle pulse after the write to word DEPTH-1 commits

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, wait counter=0, dat_sm=0, ack=0, err=0, frame_done=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer abandons the transfer with no write and no ack.
- req = cyc & stb.
- Address decode:
  - hit = (adr >= BASE_ADDR) and (adr < BASE_ADDR + 4*DEPTH) and (adr[1:0] == 0).
  - word index = (adr - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits.
- States: IDLE, WAIT, RESP.
  - IDLE: when req=1, latch adr, we, sel, dat_ms and hit. If WAIT_STATES=0, go to RESP; otherwise load the counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement the counter each cycle; at 1, go to RESP. If req drops, go to IDLE with no ack, no err and no write.
  - RESP: lasts exactly 1 cycle, then returns to IDLE.
- Response outputs:
  - ack = (state==RESP) & req & hit_latched.
  - err = (state==RESP) & req & ~hit_latched.
  - If req is low in RESP, neither is asserted and nothing is committed.
- Latency: ack is high in the 2nd cycle after req is first seen (WAIT_STATES=0), and 2+WAIT_STATES in general.
- Throughput: one transfer per (2+WAIT_STATES) cycles with stb held high. The master advances address/data on the edge where it samples ack. The next request is sampled in the IDLE cycle that follows.
- Write commit: on the rising edge that ends a RESP cycle with ack=1 and we=1. Only the byte lanes with sel[i]=1 are written; other bytes keep their old value. sel=0 commits nothing but still acks.
- Read: memory is read synchronously using the latched word index. dat_sm holds mem[index] during the RESP cycle with ack=1.
  - sel does not mask read data; all 4 bytes are returned.
  - dat_sm holds its value outside RESP. On err it is 0.
- Read-after-write: a read immediately following a write to the same word returns the new data. Consecutive transfers are separated by IDLE, so no bypass is needed.
- Error cases: out-of-range or misaligned address gives err instead of ack, no memory change, dat_sm=0.
- frame_done: asserted for exactly 1 cycle, on the cycle after the committing edge of a write with word index DEPTH-1. It is not asserted for a read or err at that address, or for a sel=0 write.
- cti and bte have no effect; every transfer is treated as classic single.
- ack and err are never high together. Neither is ever high for 2 consecutive cycles.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then release with cyc=stb=0 for 10 cycles -> ack=err=frame_done=0 and dat_sm=0 throughout.
- Single write/read, WAIT_STATES=0:
  - Write adr=0x10, dat_ms=0xDEADBEEF, sel=4'hF -> ack high exactly in the 2nd cycle.
  - Read adr=0x10 -> ack with dat_sm=0xDEADBEEF.
- Byte lanes: write 0x11223344 with sel=4'hF, then 0xAABBCCDD with sel=4'b0101 to the same word -> read returns 0x11BB33DD.
- Streaming fill:
  - Hold cyc=stb=1 and advance adr by 4 on each ack, from 0 to 4*(DEPTH-1), data = index -> DEPTH acks, one every 2 cycles, frame_done pulses once the cycle after the final committing edge.
  - Readback of the whole buffer matches.
- Errors: adr=4*DEPTH and adr=0x2 -> err for 1 cycle, no ack, dat_sm=0, memory unchanged; frame_done stays 0.
- Wait states and abort:
  - WAIT_STATES=3: ack appears 5 cycles after req.
  - Drop stb after 2 wait cycles of a write to 0x20 -> no ack, and a later read of 0x20 returns the old value.
  - Assert rst_n=0 in WAIT -> no ack, state=IDLE.

Source files
------------

// File: rtl/wshb_fb_slave.sv
// wshb_fb_slave: Wishbone classic responder backed by on-chip word memory, with end-of-frame pulse
module wshb_fb_slave #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH];
  logic [32:0] off;
  logic [AW-1:0] idx, idx_l, idx_n;
  logic [3:0] sel_l;
  logic [31:0] dat_l;
  logic req, hit, hit_l, hit_n, we_l, we_n, wr, unused;
  assign req = cyc & stb;
  // a borrow out of the subtraction lands far above SPAN, so one compare covers both bounds
  assign off = {1'b0, adr} - {1'b0, BASE_ADDR};
  assign hit = (off < SPAN) && (adr[1:0] == 2'b00);
  assign idx = off[AW+1:2];
  assign idx_n = (state == IDLE) ? idx : idx_l;
  assign hit_n = (state == IDLE) ? hit : hit_l;
  assign we_n = (state == IDLE) ? we : we_l;
  assign ack = (state == RESP) & req & hit_l;
  assign err = (state == RESP) & req & ~hit_l;
  assign wr = ack & we_l;
  assign unused = ^{cti, bte, off};
  // next state: latch in IDLE, count wait states, abort on dropped request, single RESP cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (req) begin
        state_n = (WAIT_STATES == 0) ? RESP : WAIT;
        cnt_n = 4'(WAIT_STATES);
      end
      WAIT: if (!req) state_n = IDLE;
      else begin
        state_n = (cnt == 4'd1) ? RESP : WAIT;
        cnt_n = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counter, read data (loaded on entry to RESP) and the frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      dat_sm <= 32'h0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      frame_done <= wr && (|sel_l) && (idx_l == AW'(DEPTH - 1));
      if (state_n == RESP) dat_sm <= hit_n ? (we_n ? dat_sm : mem[idx_n]) : 32'h0;
    end
  end
  // capture the request when it is first seen in IDLE
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      idx_l <= idx;
      hit_l <= hit;
      we_l <= we;
      sel_l <= sel;
      dat_l <= dat_ms;
    end
  end
  // byte-lane write commits on the edge that ends an acked write
  always_ff @(posedge clk) begin
    if (wr)
      for (int i = 0; i < 4; i++)
        if (sel_l[i]) mem[idx_l][8*i +: 8] <= dat_l[8*i +: 8];
  end
endmodule

// File: tb/tb_wshb_fb_slave.sv
// tb_wshb_fb_slave: table vectors, streaming fill, random traffic vs model, wait-state corner cases
module tb_wshb_fb_slave;
  localparam int DEPTH = 64;
  localparam logic [31:0] BASE3 = 32'h1000;
  logic clk = 0, rst_n = 0, cyc = 0, stb0 = 0, stb3 = 0, we = 0;
  logic [31:0] adr = 0, dat_ms = 0;
  logic [3:0] sel = 0;
  logic [2:0] cti = 0;
  logic [1:0] bte = 0;
  logic [31:0] dat0, dat3;
  logic ack0, err0, fd0, ack3, err3, fd3;
  int n_vec = 0, n_bad = 0, viol = 0;
  logic p0 = 0, p3 = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic w; logic [31:0] a; logic [3:0] s; logic [31:0] d;
    logic ack; logic err; logic cd; logic [31:0] rd; logic fd;
  } vec_t;

  always #5 clk = ~clk;

  wshb_fb_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb0), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat0), .ack(ack0), .err(err0), .frame_done(fd0));

  wshb_fb_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb3), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .dat_sm(dat3), .ack(ack3), .err(err3), .frame_done(fd3));

  always @(negedge clk) begin
    if ((ack0 && err0) || (ack3 && err3) || ((ack0 || err0) && p0) || ((ack3 || err3) && p3)) viol++;
    p0 = ack0 | err0;
    p3 = ack3 | err3;
  end

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                              input logic ak, input logic er, input logic cd, input logic [31:0] rd, input logic fd);
    vec_t v;
    v.w = w; v.a = a; v.s = s; v.d = d; v.ack = ak; v.err = er; v.cd = cd; v.rd = rd; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic xfer(input bit d, input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                      output logic a_o, output logic e_o, output logic [31:0] rd_o, output logic fd_o, output int lat);
    @(posedge clk); #1;
    cyc = 1; stb0 = !d; stb3 = d; we = w; adr = a; sel = s; dat_ms = wd;
    cti = 3'($urandom); bte = 2'($urandom);
    a_o = 0; e_o = 0; rd_o = 0; lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      if ((d ? ack3 : ack0) || (d ? err3 : err0)) begin
        lat = n;
        a_o = d ? ack3 : ack0;
        e_o = d ? err3 : err0;
        rd_o = d ? dat3 : dat0;
      end
    end
    @(posedge clk); #1;
    cyc = 0; stb0 = 0; stb3 = 0;
    @(negedge clk);
    fd_o = d ? fd3 : fd0;
  endtask

  initial begin
    vec_t tbl [17];
    logic a_o, e_o, f_o, w, hit;
    logic [31:0] r_o, a, wd;
    logic [3:0] s;
    int lat, acks, cyc_n, fds, gaps, seen, idx, r;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle0_%0d", i), 64'({ack0, err0, fd0, dat0}), 64'd0);
      chk($sformatf("idle3_%0d", i), 64'({ack3, err3, fd3, dat3}), 64'd0);
    end

    tbl[0]  = mk(1, 32'h10,  4'hF, 32'hDEADBEEF, 1, 0, 0, 32'h0,        0);
    tbl[1]  = mk(0, 32'h10,  4'hF, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 32'h14,  4'hF, 32'h11223344, 1, 0, 0, 32'h0,        0);
    tbl[3]  = mk(1, 32'h14,  4'h5, 32'hAABBCCDD, 1, 0, 0, 32'h0,        0);
    tbl[4]  = mk(0, 32'h14,  4'h0, 32'h0,        1, 0, 1, 32'h11BB33DD, 0);
    tbl[5]  = mk(1, 32'h100, 4'hF, 32'h0,        0, 1, 1, 32'h0,        0);
    tbl[6]  = mk(0, 32'h2,   4'hF, 32'h0,        0, 1, 1, 32'h0,        0);
    tbl[7]  = mk(1, 32'h12,  4'hF, 32'hFFFFFFFF, 0, 1, 1, 32'h0,        0);
    tbl[8]  = mk(0, 32'h10,  4'hF, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0);
    tbl[9]  = mk(1, 32'hFC,  4'h0, 32'h12345678, 1, 0, 0, 32'h0,        0);
    tbl[10] = mk(1, 32'hFC,  4'hF, 32'h0BADF00D, 1, 0, 0, 32'h0,        1);
    tbl[11] = mk(0, 32'hFC,  4'hF, 32'h0,        1, 0, 1, 32'h0BADF00D, 0);
    tbl[12] = mk(1, 32'hFC,  4'h3, 32'hFFFF0000, 1, 0, 0, 32'h0,        1);
    tbl[13] = mk(0, 32'hFC,  4'hF, 32'h0,        1, 0, 1, 32'h0BAD0000, 0);
    tbl[14] = mk(0, 32'h100, 4'hF, 32'h0,        0, 1, 1, 32'h0,        0);
    tbl[15] = mk(1, 32'h10,  4'h0, 32'h0,        1, 0, 0, 32'h0,        0);
    tbl[16] = mk(0, 32'h10,  4'hF, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0);
    for (int i = 0; i < 17; i++) begin
      xfer(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, a_o, e_o, r_o, f_o, lat);
      chk($sformatf("v%0d_resp", i), 64'({a_o, e_o}), 64'({tbl[i].ack, tbl[i].err}));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'd2);
      if (tbl[i].cd) chk($sformatf("v%0d_dat", i), 64'(r_o), 64'(tbl[i].rd));
      chk($sformatf("v%0d_fd", i), 64'(f_o), 64'(tbl[i].fd));
    end

    @(posedge clk); #1;
    cyc = 1; stb0 = 1; we = 1; sel = 4'hF; adr = 0; dat_ms = 0;
    acks = 0; cyc_n = 0; fds = 0; gaps = 0;
    while (acks < DEPTH && cyc_n < DEPTH * 4) begin
      @(negedge clk);
      cyc_n++;
      if (fd0) fds++;
      if (ack0) begin
        acks++;
        if (cyc_n != 2 * acks) gaps++;
        @(posedge clk); #1;
        adr = adr + 32'd4;
        dat_ms = 32'(acks);
        if (acks == DEPTH) begin cyc = 0; stb0 = 0; end
      end
    end
    @(negedge clk);
    chk("fill_acks", 64'(acks), 64'(DEPTH));
    chk("fill_gaps", 64'(gaps), 64'd0);
    chk("fill_early_fd", 64'(fds), 64'd0);
    chk("fill_fd", 64'(fd0), 64'd1);
    @(negedge clk);
    chk("fill_fd_once", 64'(fd0), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 32'(i);
      xfer(0, 0, 32'(i * 4), 4'hF, 32'h0, a_o, e_o, r_o, f_o, lat);
      chk($sformatf("rb%0d", i), 64'({a_o, r_o}), 64'({1'b1, 32'(i)}));
    end

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, DEPTH - 1));
      a = (r == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 63)) * 32'd4 :
          (r == 1) ? 32'(idx * 4) + 32'($urandom_range(1, 3)) :
          (r == 2) ? 32'((DEPTH - 1) * 4) : 32'(idx * 4);
      s = 4'($urandom_range(0, 15));
      wd = $urandom;
      hit = (a < 32'(4 * DEPTH)) && (a % 4 == 0);
      xfer(0, w, a, s, wd, a_o, e_o, r_o, f_o, lat);
      chk($sformatf("rnd%0d_resp", i), 64'({a_o, e_o}), 64'({hit, !hit}));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd2);
      if (!hit) chk($sformatf("rnd%0d_errdat", i), 64'(r_o), 64'd0);
      else if (!w) chk($sformatf("rnd%0d_dat", i), 64'(r_o), 64'(model[a / 4]));
      chk($sformatf("rnd%0d_fd", i), 64'(f_o), 64'(w && hit && s != 0 && a / 4 == DEPTH - 1));
      if (w && hit)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[a / 4][8*b +: 8] = wd[8*b +: 8];
    end

    xfer(1, 1, BASE3 + 32'h20, 4'hF, 32'hCAFEF00D, a_o, e_o, r_o, f_o, lat);
    chk("ws3_wr_resp", 64'({a_o, e_o}), 64'b10);
    chk("ws3_wr_lat", 64'(lat), 64'd5);
    xfer(1, 1, BASE3 + 32'h24, 4'hF, 32'h5A5A5A5A, a_o, e_o, r_o, f_o, lat);
    chk("ws3_wr2_resp", 64'({a_o, e_o}), 64'b10);

    @(posedge clk); #1;
    cyc = 1; stb3 = 1; we = 1; adr = BASE3 + 32'h20; sel = 4'hF; dat_ms = 32'h12345678;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack3 || err3) seen++;
      if (k == 3) begin @(posedge clk); #1; cyc = 0; stb3 = 0; end
    end
    chk("abort_noack", 64'(seen), 64'd0);
    xfer(1, 0, BASE3 + 32'h20, 4'hF, 32'h0, a_o, e_o, r_o, f_o, lat);
    chk("abort_old", 64'({a_o, r_o}), 64'({1'b1, 32'hCAFEF00D}));
    chk("abort_rd_lat", 64'(lat), 64'd5);

    @(posedge clk); #1;
    cyc = 1; stb3 = 1; we = 1; adr = BASE3 + 32'h24; sel = 4'hF; dat_ms = 32'hFFFFFFFF;
    seen = 0;
    @(negedge clk); if (ack3 || err3) seen++;
    @(negedge clk); if (ack3 || err3) seen++;
    rst_n = 0;
    repeat (2) begin @(negedge clk); if (ack3 || err3) seen++; end
    cyc = 0; stb3 = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (6) begin @(negedge clk); if (ack3 || err3) seen++; end
    chk("rst_wait_noack", 64'(seen), 64'd0);
    xfer(1, 0, BASE3 + 32'h24, 4'hF, 32'h0, a_o, e_o, r_o, f_o, lat);
    chk("rst_wait_old", 64'({a_o, r_o}), 64'({1'b1, 32'h5A5A5A5A}));
    chk("rst_wait_lat", 64'(lat), 64'd5);

    xfer(1, 0, 32'h20, 4'hF, 32'h0, a_o, e_o, r_o, f_o, lat);
    chk("ws3_below_base", 64'({a_o, e_o, r_o}), 64'({2'b01, 32'h0}));
    chk("ws3_err_lat", 64'(lat), 64'd5);
    xfer(1, 1, BASE3 + 32'(4 * DEPTH), 4'hF, 32'h1, a_o, e_o, r_o, f_o, lat);
    chk("ws3_above_top", 64'({a_o, e_o, r_o, f_o}), 64'({2'b01, 32'h0, 1'b0}));

    chk("protocol", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
